// File: rtl/riscv_decode_alu.sv
// RV32I single-cycle control decoder and ALU with branch resolution.
// Only state is the sticky illegal-instruction flag.
module riscv_decode_alu #(
  parameter int BITNESS        = 32,
  parameter int ALU_CTRL_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [31:0]               instr_i,
  input  logic [BITNESS-1:0]        op1_i,
  input  logic [BITNESS-1:0]        op2_i,
  output logic [BITNESS-1:0]        alu_o,
  output logic                      zero_o,
  output logic [1:0]                pcSrc_o,
  output logic [1:0]                resultSrc_o,
  output logic                      regWrite_o,
  output logic                      memWrite_o,
  output logic                      aluSrc_o,
  output logic [2:0]                immSrc_o,
  output logic [ALU_CTRL_WIDTH-1:0] aluControl_o,
  output logic                      illegal_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD  = ALU_CTRL_WIDTH'(4'b0000);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB  = ALU_CTRL_WIDTH'(4'b0001);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND  = ALU_CTRL_WIDTH'(4'b0010);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR   = ALU_CTRL_WIDTH'(4'b0011);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_XOR  = ALU_CTRL_WIDTH'(4'b0100);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLL  = ALU_CTRL_WIDTH'(4'b0101);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRL  = ALU_CTRL_WIDTH'(4'b0110);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRA  = ALU_CTRL_WIDTH'(4'b0111);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT  = ALU_CTRL_WIDTH'(4'b1000);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLTU = ALU_CTRL_WIDTH'(4'b1001);

  typedef enum logic [1:0] {
    PC_SEQ,
    PC_BRANCH,
    PC_JAL,
    PC_JALR
  } pc_kind_t;

  logic [6:0]                w_opcode;
  logic [2:0]                w_funct3;
  logic                      w_funct7_5;
  logic                      w_illegal;
  logic                      w_taken;
  pc_kind_t                  w_pc_kind;
  logic [ALU_CTRL_WIDTH-1:0] w_alu_ctrl;
  logic [4:0]                w_shamt;
  logic                      r_illegal;

  assign w_opcode   = instr_i[6:0];
  assign w_funct3   = instr_i[14:12];
  assign w_funct7_5 = instr_i[30];
  assign w_shamt    = op2_i[4:0];

  // Shared R/I-ALU mapping; subtraction only exists in the register form.
  function automatic logic [ALU_CTRL_WIDTH-1:0] alu_sel(input logic [2:0] f3,
                                                        input logic f7_5,
                                                        input logic is_reg);
    case (f3)
      3'b000:  alu_sel = (is_reg && f7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_sel = ALU_SLL;
      3'b010:  alu_sel = ALU_SLT;
      3'b011:  alu_sel = ALU_SLTU;
      3'b100:  alu_sel = ALU_XOR;
      3'b101:  alu_sel = f7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_sel = ALU_OR;
      default: alu_sel = ALU_AND;
    endcase
  endfunction

  always_comb begin
    regWrite_o  = 1'b0;
    memWrite_o  = 1'b0;
    aluSrc_o    = 1'b0;
    immSrc_o    = 3'b000;
    resultSrc_o = 2'b01;
    w_alu_ctrl  = ALU_ADD;
    w_pc_kind   = PC_SEQ;
    w_illegal   = 1'b0;
    case (w_opcode)
      OP_R: begin
        regWrite_o = 1'b1;
        w_alu_ctrl = alu_sel(w_funct3, w_funct7_5, 1'b1);
      end
      OP_I: begin
        regWrite_o = 1'b1;
        aluSrc_o   = 1'b1;
        w_alu_ctrl = alu_sel(w_funct3, w_funct7_5, 1'b0);
      end
      OP_LOAD: begin
        regWrite_o  = 1'b1;
        aluSrc_o    = 1'b1;
        resultSrc_o = 2'b00;
        w_illegal   = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
      end
      OP_STORE: begin
        memWrite_o = 1'b1;
        aluSrc_o   = 1'b1;
        immSrc_o   = 3'b001;
        w_illegal  = w_funct3[2] || (w_funct3[1:0] == 2'b11);
      end
      OP_BRANCH: begin
        immSrc_o  = 3'b010;
        w_pc_kind = PC_BRANCH;
        case (w_funct3[2:1])
          2'b00:   w_alu_ctrl = ALU_SUB;
          2'b10:   w_alu_ctrl = ALU_SLT;
          2'b11:   w_alu_ctrl = ALU_SLTU;
          default: w_illegal  = 1'b1;
        endcase
      end
      OP_JAL: begin
        regWrite_o  = 1'b1;
        immSrc_o    = 3'b100;
        resultSrc_o = 2'b10;
        w_pc_kind   = PC_JAL;
      end
      OP_JALR: begin
        regWrite_o  = 1'b1;
        aluSrc_o    = 1'b1;
        resultSrc_o = 2'b10;
        w_pc_kind   = PC_JALR;
        w_illegal   = (w_funct3 != 3'b000);
      end
      OP_LUI: begin
        regWrite_o  = 1'b1;
        immSrc_o    = 3'b011;
        resultSrc_o = 2'b11;
      end
      default: w_illegal = 1'b1;
    endcase
    // Illegal words fall back to inert defaults so nothing is written.
    if (w_illegal) begin
      regWrite_o  = 1'b0;
      memWrite_o  = 1'b0;
      aluSrc_o    = 1'b0;
      immSrc_o    = 3'b000;
      resultSrc_o = 2'b01;
      w_alu_ctrl  = ALU_ADD;
      w_pc_kind   = PC_SEQ;
    end
  end

  assign aluControl_o = w_alu_ctrl;

  always_comb begin
    alu_o = '0;
    case (w_alu_ctrl)
      ALU_ADD:  alu_o = op1_i + op2_i;
      ALU_SUB:  alu_o = op1_i - op2_i;
      ALU_AND:  alu_o = op1_i & op2_i;
      ALU_OR:   alu_o = op1_i | op2_i;
      ALU_XOR:  alu_o = op1_i ^ op2_i;
      ALU_SLL:  alu_o = op1_i << w_shamt;
      ALU_SRL:  alu_o = op1_i >> w_shamt;
      ALU_SRA:  alu_o = $signed(op1_i) >>> w_shamt;
      ALU_SLT:  alu_o = {{(BITNESS-1){1'b0}}, ($signed(op1_i) < $signed(op2_i))};
      ALU_SLTU: alu_o = {{(BITNESS-1){1'b0}}, (op1_i < op2_i)};
      default:  alu_o = '0;
    endcase
  end

  assign zero_o = (alu_o == '0);

  // BEQ/BGE/BGEU take on zero; BNE/BLT/BLTU on non-zero.
  always_comb begin
    w_taken = 1'b0;
    case (w_funct3)
      3'b000, 3'b101, 3'b111: w_taken = zero_o;
      3'b001, 3'b100, 3'b110: w_taken = !zero_o;
      default:                w_taken = 1'b0;
    endcase
  end

  always_comb begin
    pcSrc_o = 2'b00;
    case (w_pc_kind)
      PC_BRANCH: pcSrc_o = w_taken ? 2'b01 : 2'b00;
      PC_JAL:    pcSrc_o = 2'b01;
      PC_JALR:   pcSrc_o = 2'b10;
      default:   pcSrc_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_illegal <= 1'b0;
    end else if (w_illegal) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal_o = r_illegal;

endmodule

// File: tb/tb_riscv_decode_alu.sv
// Directed-vector bench for riscv_decode_alu: decode controls, ALU results,
// branch resolution and the sticky illegal flag.
module tb_riscv_decode_alu;

  logic        clk_i;
  logic        rst_ni;
  logic [31:0] instr_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic [31:0] alu_o;
  logic        zero_o;
  logic [1:0]  pcSrc_o;
  logic [1:0]  resultSrc_o;
  logic        regWrite_o;
  logic        memWrite_o;
  logic        aluSrc_o;
  logic [2:0]  immSrc_o;
  logic [3:0]  aluControl_o;
  logic        illegal_o;

  int n_checks = 0;
  int n_pass   = 0;

  riscv_decode_alu #(.BITNESS(32), .ALU_CTRL_WIDTH(4)) u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .instr_i      (instr_i),
    .op1_i        (op1_i),
    .op2_i        (op2_i),
    .alu_o        (alu_o),
    .zero_o       (zero_o),
    .pcSrc_o      (pcSrc_o),
    .resultSrc_o  (resultSrc_o),
    .regWrite_o   (regWrite_o),
    .memWrite_o   (memWrite_o),
    .aluSrc_o     (aluSrc_o),
    .immSrc_o     (immSrc_o),
    .aluControl_o (aluControl_o),
    .illegal_o    (illegal_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic apply(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    instr_i = ins;
    op1_i   = a;
    op2_i   = b;
    #1;
  endtask

  initial begin
    rst_ni  = 1'b0;
    instr_i = 32'h0000_0017;  // AUIPC under reset
    op1_i   = '0;
    op2_i   = '0;
    #1;
    check("rst_illegal", 32'(illegal_o), 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_wins", 32'(illegal_o), 32'h0);

    apply(32'h0000_0013, 32'h0, 32'h0);
    rst_ni = 1'b1;

    // sub x0,x1,x2
    apply(32'h4020_8033, 32'd5, 32'd7);
    check("sub_ctl",  32'(aluControl_o), 32'h1);
    check("sub_alu",  alu_o, 32'hFFFF_FFFE);
    check("sub_zero", 32'(zero_o), 32'h0);
    check("sub_rw",   32'(regWrite_o), 32'h1);
    check("sub_asrc", 32'(aluSrc_o), 32'h0);
    check("sub_res",  32'(resultSrc_o), 32'h1);

    // add / and / or / xor / sll / slt register forms
    apply(32'h0020_8033, 32'd5, 32'd7);
    check("add_alu", alu_o, 32'd12);
    apply(32'h0020_F033, 32'hF0F0_1234, 32'h0FF0_FF00);
    check("and_alu", alu_o, 32'h00F0_1200);
    check("and_ctl", 32'(aluControl_o), 32'h2);
    apply(32'h0020_E033, 32'hF000_0001, 32'h0000_0F10);
    check("or_alu", alu_o, 32'hF000_0F11);
    apply(32'h0020_C033, 32'hFFFF_0000, 32'h0F0F_0F0F);
    check("xor_alu", alu_o, 32'hF0F0_0F0F);
    apply(32'h0020_9033, 32'h0000_0003, 32'h0000_0024);
    check("sll_alu", alu_o, 32'h0000_0030);
    apply(32'h0020_A033, 32'hFFFF_FFFE, 32'h0000_0001);
    check("slt_alu", alu_o, 32'h1);
    apply(32'h0020_8033, 32'h0, 32'h0);
    check("add_zero", 32'(zero_o), 32'h1);

    // addi with bit30 set is still add
    apply(32'h4000_0013, 32'd5, 32'd7);
    check("addi_ctl",  32'(aluControl_o), 32'h0);
    check("addi_alu",  alu_o, 32'd12);
    check("addi_asrc", 32'(aluSrc_o), 32'h1);

    // srai / srli
    apply(32'h4000_5013, 32'h8000_0000, 32'd4);
    check("srai_alu", alu_o, 32'hF800_0000);
    apply(32'h0000_5013, 32'h8000_0000, 32'd4);
    check("srli_alu", alu_o, 32'h0800_0000);

    // bne
    apply(32'h0020_9463, 32'd3, 32'd3);
    check("bne_nt_pc",  32'(pcSrc_o), 32'h0);
    check("bne_nt_z",   32'(zero_o), 32'h1);
    check("bne_rw",     32'(regWrite_o), 32'h0);
    check("bne_imm",    32'(immSrc_o), 32'h2);
    apply(32'h0020_9463, 32'd3, 32'd4);
    check("bne_t_pc",   32'(pcSrc_o), 32'h1);
    check("bne_t_imm",  32'(immSrc_o), 32'h2);
    check("bne_t_rw",   32'(regWrite_o), 32'h0);
    // beq taken
    apply(32'h0020_8463, 32'd9, 32'd9);
    check("beq_t_pc", 32'(pcSrc_o), 32'h1);

    // bge / bltu signedness
    apply(32'h0020_D463, 32'hFFFF_FFFF, 32'd1);
    check("bge_alu", alu_o, 32'h1);
    check("bge_pc",  32'(pcSrc_o), 32'h0);
    apply(32'h0020_E463, 32'hFFFF_FFFF, 32'd1);
    check("bltu_alu", alu_o, 32'h0);
    check("bltu_pc",  32'(pcSrc_o), 32'h0);
    // blt taken
    apply(32'h0020_C463, 32'hFFFF_FFFF, 32'd1);
    check("blt_pc", 32'(pcSrc_o), 32'h1);

    // jal / jalr / lui / sw / lw
    apply(32'h0000_006F, 32'h0, 32'h0);
    check("jal_pc",  32'(pcSrc_o), 32'h1);
    check("jal_res", 32'(resultSrc_o), 32'h2);
    check("jal_imm", 32'(immSrc_o), 32'h4);
    check("jal_rw",  32'(regWrite_o), 32'h1);
    apply(32'h0000_0067, 32'h100, 32'h8);
    check("jalr_alu", alu_o, 32'h108);
    check("jalr_pc",  32'(pcSrc_o), 32'h2);
    check("jalr_res", 32'(resultSrc_o), 32'h2);
    apply(32'h0000_0037, 32'h0, 32'h0);
    check("lui_res", 32'(resultSrc_o), 32'h3);
    check("lui_imm", 32'(immSrc_o), 32'h3);
    apply(32'h0000_2023, 32'h40, 32'h4);
    check("sw_mw",  32'(memWrite_o), 32'h1);
    check("sw_rw",  32'(regWrite_o), 32'h0);
    check("sw_imm", 32'(immSrc_o), 32'h1);
    check("sw_alu", alu_o, 32'h44);
    apply(32'h0000_2003, 32'h40, 32'h4);
    check("lw_res", 32'(resultSrc_o), 32'h0);
    check("lw_rw",  32'(regWrite_o), 32'h1);

    @(posedge clk_i);
    #1;
    check("legal_no_flag", 32'(illegal_o), 32'h0);

    // auipc sets the sticky flag
    apply(32'h0000_0017, 32'h1, 32'h2);
    check("auipc_rw",  32'(regWrite_o), 32'h0);
    check("auipc_pc",  32'(pcSrc_o), 32'h0);
    check("auipc_res", 32'(resultSrc_o), 32'h1);
    check("auipc_pre", 32'(illegal_o), 32'h0);
    @(posedge clk_i);
    #1;
    check("auipc_flag", 32'(illegal_o), 32'h1);

    // other illegal encodings fall back to defaults
    apply(32'h0000_3003, 32'h1, 32'h2);
    check("ld011_rw",   32'(regWrite_o), 32'h0);
    check("ld011_asrc", 32'(aluSrc_o), 32'h0);
    apply(32'h0000_3023, 32'h1, 32'h2);
    check("sd_mw", 32'(memWrite_o), 32'h0);
    apply(32'h0020_A463, 32'd3, 32'd4);
    check("b010_pc",  32'(pcSrc_o), 32'h0);
    check("b010_imm", 32'(immSrc_o), 32'h0);
    check("b010_ctl", 32'(aluControl_o), 32'h0);
    apply(32'h0000_1067, 32'h100, 32'h8);
    check("jalr_f3_pc", 32'(pcSrc_o), 32'h0);

    // legal instructions do not clear the flag
    apply(32'h0020_8033, 32'd1, 32'd1);
    repeat (3) @(posedge clk_i);
    #1;
    check("sticky", 32'(illegal_o), 32'h1);

    // async reset clears it mid-cycle
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_clr", 32'(illegal_o), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/riscv_decode_alu.md
Name: riscv_decode_alu

Overview:
- Single-cycle RV32I decode-and-execute slice: the control decoder and the ALU in one block.
- Decodes the current instruction word into datapath controls, performs the ALU operation on operands supplied by the register file and the operand-B mux, and resolves branches internally from the ALU zero flag.
- Control and ALU paths are purely combinational, so the surrounding CPU stays single-cycle.
- The only state is a sticky illegal-instruction flag.

Parameters:
- BITNESS, 32, operand/result width.
- ALU_CTRL_WIDTH, 4, width of ALU control code.

Ports:
- clk_i  in  1  clock; the sticky flag updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- instr_i  in  32  current instruction word.
- op1_i  in  BITNESS  ALU operand A (rs1).
- op2_i  in  BITNESS  ALU operand B (rs2 or immediate, muxed outside).
- alu_o  out  BITNESS  ALU result.
- zero_o  out  1  alu_o == 0.
- pcSrc_o  out  2  00 = pc+4; 01 = pc+imm (taken branch or JAL); 10 = alu_o (JALR); 11 unused.
- resultSrc_o  out  2  00 = memory read data; 01 = alu_o; 10 = pc+4; 11 = immediate (LUI).
- regWrite_o  out  1  register file write enable.
- memWrite_o  out  1  data memory write enable.
- aluSrc_o  out  1  1 = operand B is the immediate; 0 = operand B is rs2.
- immSrc_o  out  3  000 I, 001 S, 010 B, 011 U, 100 J.
- aluControl_o  out  ALU_CTRL_WIDTH  ALU operation actually applied.
- illegal_o  out  1  sticky illegal-instruction flag.

Behaviour:
- Instruction field decode: opcode = instr_i[6:0], funct3 = instr_i[14:12], funct7_5 = instr_i[30].
- ALU codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount is op2_i[4:0].
  - 1000 SLT (signed), 1001 SLTU; both produce 1 or 0 zero-extended.
  - Any other code produces 0.
- Arithmetic wraps modulo 2^BITNESS; no overflow or carry output.
- R-type, opcode 0110011: regWrite=1, aluSrc=0, resultSrc=01. funct3 selects the operation: 000 add/sub (sub when funct7_5=1), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra (sra when funct7_5=1), 110 or, 111 and.
- I-ALU, opcode 0010011: same mapping with aluSrc=1 and immSrc=000. funct7_5 is ignored for funct3=000 (no subi) and selects SRAI for funct3=101.
- Load, opcode 0000011: ADD, aluSrc=1, immSrc=000, resultSrc=00, regWrite=1. Legal funct3 values: 000, 001, 010, 100, 101.
- Store, opcode 0100011: ADD, aluSrc=1, immSrc=001, memWrite=1, regWrite=0. Legal funct3 values: 000 to 010.
- Branch, opcode 1100011: aluSrc=0, immSrc=010, regWrite=0.
  - BEQ/BNE use SUB; taken when zero / not zero respectively.
  - BLT/BGE use SLT; taken when not zero / zero respectively.
  - BLTU/BGEU use SLTU; taken when not zero / zero respectively.
  - Taken gives pcSrc=01, otherwise 00. funct3 010 or 011 is illegal.
- JAL, opcode 1101111: immSrc=100, pcSrc=01, resultSrc=10, regWrite=1.
- JALR, opcode 1100111, funct3 must be 000: ADD, aluSrc=1, immSrc=000, pcSrc=10, resultSrc=10, regWrite=1.
- LUI, opcode 0110111: immSrc=011, resultSrc=11, regWrite=1.
- AUIPC and all other opcodes are illegal.
- Illegal instruction: regWrite=0, memWrite=0, pcSrc=00. All other outputs take their defaults: aluSrc=0, immSrc=000, resultSrc=01, aluControl=ADD.
- Control and ALU outputs are combinational with zero latency and are unaffected by reset.
- illegal_o:
  - Cleared to 0 asynchronously while rst_ni=0.
  - Set on a rising clk_i edge when the current instruction is illegal and rst_ni=1.
  - Stays 1 until the next reset; it is never cleared by legal instructions.
  - Reset asserted in the same cycle as an illegal instruction: reset wins and illegal_o stays 0.

Test Plan:
- R-type sub: instr 0x40208033 (sub x0,x1,x2), op1=5, op2=7 -> aluControl=0001, alu_o=0xFFFFFFFE, zero_o=0, regWrite=1, aluSrc=0, resultSrc=01.
- BNE taken/not taken: instr 0x00209463 with op1=3, op2=3 -> pcSrc=00, zero_o=1; with op1=3, op2=4 -> pcSrc=01. In both cases regWrite=0 and immSrc=010.
- BGE/BLTU signedness: BGE (funct3 101) with op1=0xFFFFFFFF, op2=1 -> SLT gives alu_o=1, pcSrc=00. BLTU (funct3 110) with the same operands -> SLTU gives alu_o=0, pcSrc=00.
- SRAI vs SRLI: op1=0x80000000, op2=4. funct7_5=1 -> alu_o=0xF8000000. funct7_5=0 -> alu_o=0x08000000.
- JAL/JALR/LUI/store:
  - JAL -> pcSrc=01, resultSrc=10, immSrc=100.
  - JALR with op1=0x100, op2=8 -> alu_o=0x108, pcSrc=10.
  - LUI -> resultSrc=11, immSrc=011.
  - sw -> memWrite=1, regWrite=0, immSrc=001.
- Illegal sticky: reset low, then AUIPC for one clock -> regWrite=0 and illegal_o=1 after the edge. illegal_o stays 1 through subsequent legal instructions and returns to 0 immediately when rst_ni is driven low asynchronously.
